macc_operand_sequencer: RTL and testbench

Upstream feeder for the `macc_417` multiply-accumulate unit. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It issues one pair per cycle to the MACC, driving `accumulate_enable` so that each vector starts a fresh accumulation, and it pulses `vec_done` in the cycle the MACC `result` holds the finished dot product.

---
 rtl/macc_operand_sequencer_if.sv | 23 ++
 rtl/macc_operand_sequencer.sv | 147 ++++++++++++++
 tb/tb_macc_operand_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/macc_operand_sequencer_if.sv
// -----------------------------------------------------------------------------
// macc_operand_sequencer_if
//   Operand-pair stream into the MACC operand sequencer. Each beat carries a
//   multiplicand, a multiplier and an end-of-vector marker.
//
//   s_valid  producer -> consumer  pair valid
//   s_ready  consumer -> producer  consumer can accept a pair this cycle
//   s_a      producer -> consumer  multiplicand (32 bits)
//   s_b      producer -> consumer  multiplier   (32 bits)
//   s_last   producer -> consumer  final pair of the current vector
//
//   master: the producer side; slave: the sequencer side.
// -----------------------------------------------------------------------------
interface macc_operand_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        s_last;

  modport master (output s_valid, output s_a, output s_b, output s_last, input s_ready);
  modport slave  (input s_valid, input s_a, input s_b, input s_last, output s_ready);
endinterface

// File: rtl/macc_operand_sequencer.sv
// -----------------------------------------------------------------------------
// macc_operand_sequencer
//   Buffers operand pairs in a DEPTH-entry FIFO and issues one pair per cycle
//   to a downstream multiply-accumulate unit. The first pair of every vector
//   is issued with macc_ae=0 so the MACC restarts its sum; later pairs
//   accumulate. vec_done pulses in the cycle the MACC result holds the
//   finished dot product.
//
//   clk         clock, rising edge
//   rst         asynchronous, active-low reset
//   run         issue enable; 0 holds the MACC idle and stops FIFO pops
//   s           operand stream (slave side of macc_operand_sequencer_if)
//   macc_a/b    registered operands to the MACC
//   macc_ae     registered accumulate_enable to the MACC
//   vec_done    one-cycle pulse, MACC result is final this cycle
//   elem_count  pairs issued so far in the current vector
//   vec_count   completed vectors, wraps
// -----------------------------------------------------------------------------
module macc_operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  macc_operand_sequencer_if.slave       s,
  output logic [31:0]                   macc_a,
  output logic [31:0]                   macc_b,
  output logic                          macc_ae,
  output logic                          vec_done,
  output logic [CNT_W-1:0]              elem_count,
  output logic [CNT_W-1:0]              vec_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        last;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  typedef enum logic {START, ACCUM} state_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              push, pop;
  entry_t            head;

  state_t            state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              ae_q, ae_d;
  logic              last_issue_q, last_issue_d;
  logic              vec_done_q;
  logic [CNT_W-1:0]  elem_q, elem_d;
  logic [CNT_W-1:0]  vec_q;

  // Pop depends only on the registered count, so a word pushed this edge
  // cannot be issued before the next one.
  assign s.s_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign push      = s.s_valid && s.s_ready;
  assign pop       = run && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: FIFO storage has no reset; count_q alone decides which entries are
  // live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{last: s.s_last, a: s.s_a, b: s.s_b};
  end

  // Issue FSM next-state and datapath.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    elem_d       = elem_q;
    a_d          = '0;
    b_d          = '0;
    ae_d         = 1'b1;   // idle drive: 0*0 accumulated keeps result
    last_issue_d = 1'b0;
    if (pop) begin
      a_d          = head.a;
      b_d          = head.b;
      last_issue_d = head.last;
      if (state_q == START) begin
        ae_d   = 1'b0;
        elem_d = CNT_W'(1);
      end else begin
        elem_d = elem_q + 1'b1;
      end
      state_d = head.last ? START : ACCUM;
    end else if (last_issue_q) begin
      // A back-to-back issue takes priority above and restarts at 1.
      elem_d = '0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= START;
      a_q          <= '0;
      b_q          <= '0;
      ae_q         <= 1'b1;
      last_issue_q <= 1'b0;
      vec_done_q   <= 1'b0;
      elem_q       <= '0;
      vec_q        <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ae_q         <= ae_d;
      elem_q       <= elem_d;
      // The MACC captures the last pair one edge after it is issued, so the
      // done pulse and vector count trail the last-issue flag by one edge.
      last_issue_q <= last_issue_d;
      vec_done_q   <= last_issue_q;
      vec_q        <= vec_q + CNT_W'(last_issue_q);
    end
  end

  assign macc_a     = a_q;
  assign macc_b     = b_q;
  assign macc_ae    = ae_q;
  assign vec_done   = vec_done_q;
  assign elem_count = elem_q;
  assign vec_count  = vec_q;

endmodule

// File: tb/tb_macc_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_macc_operand_sequencer
//   Directed bench for macc_operand_sequencer. A behavioural MACC sits on the
//   issue port so dot-product results can be checked at vec_done.
// -----------------------------------------------------------------------------
module tb_macc_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] macc_a, macc_b;
  logic        macc_ae, vec_done;
  logic [15:0] elem_count, vec_count;

  int n_vec = 0;
  int n_err = 0;

  macc_operand_sequencer_if sif ();

  macc_operand_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .s          (sif),
    .macc_a     (macc_a),
    .macc_b     (macc_b),
    .macc_ae    (macc_ae),
    .vec_done   (vec_done),
    .elem_count (elem_count),
    .vec_count  (vec_count)
  );

  always #5 clk = ~clk;

  // Downstream MACC: updates every edge, no stall.
  logic [63:0] res = '0;
  always @(posedge clk)
    res <= macc_ae ? res + 64'(macc_a) * 64'(macc_b) : 64'(macc_a) * 64'(macc_b);

  // One cycle row: inputs applied before the edge, expectations after it.
  typedef struct {
    logic        v;
    logic [31:0] a, b;
    logic        l, r;
    logic [31:0] ea, eb;
    logic        eae, evd;
    logic [63:0] eres;
    int          eel;
  } row_t;

  function automatic row_t mk(logic v, logic [31:0] a, logic [31:0] b, logic l, logic r,
                              logic [31:0] ea, logic [31:0] eb, logic eae, logic evd,
                              logic [63:0] eres, int eel);
    row_t x;
    x.v = v; x.a = a; x.b = b; x.l = l; x.r = r;
    x.ea = ea; x.eb = eb; x.eae = eae; x.evd = evd; x.eres = eres; x.eel = eel;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic l);
    sif.s_valid = v;
    sif.s_a     = a;
    sif.s_b     = b;
    sif.s_last  = l;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    run = 1'b0;
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if ({sif.s_ready, macc_a, macc_b, macc_ae, vec_done, elem_count, vec_count} !==
        {1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 16'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b a=%0d b=%0d ae=%b done=%b elem=%0d vec=%0d, want rdy=1 a=0 b=0 ae=1 done=0 elem=0 vec=0",
               sif.s_ready, macc_a, macc_b, macc_ae, vec_done, elem_count, vec_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({macc_a, macc_b, macc_ae, vec_done} !== {32'd0, 32'd0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL idle_after_reset[%0d]: got a=%0d b=%0d ae=%b done=%b, want a=0 b=0 ae=1 done=0",
                 i, macc_a, macc_b, macc_ae, vec_done);
      end
    end
  endtask

  task automatic test_single_vector();
    row_t rows[$];
    rows.push_back(mk(1, 1, 3, 0, 1,  0, 0, 1, 0,  0, 0));
    rows.push_back(mk(1, 2, 6, 0, 1,  1, 3, 0, 0,  0, 1));
    rows.push_back(mk(1, 3, 9, 1, 1,  2, 6, 1, 0,  0, 2));
    rows.push_back(mk(0, 0, 0, 0, 1,  3, 9, 1, 0,  0, 3));
    rows.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 1, 42, 0));
    rows.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 0,  0, 0));
    foreach (rows[i]) begin
      drive(rows[i].v, rows[i].a, rows[i].b, rows[i].l);
      run = rows[i].r;
      tick();
      n_vec++;
      if ({macc_a, macc_b, macc_ae, vec_done} !== {rows[i].ea, rows[i].eb, rows[i].eae, rows[i].evd}) begin
        n_err++;
        $display("FAIL single[%0d]: got a=%0d b=%0d ae=%b done=%b, want a=%0d b=%0d ae=%b done=%b",
                 i, macc_a, macc_b, macc_ae, vec_done, rows[i].ea, rows[i].eb, rows[i].eae, rows[i].evd);
      end
      n_vec++;
      if (elem_count !== 16'(rows[i].eel)) begin
        n_err++;
        $display("FAIL single_elem[%0d]: got %0d, want %0d", i, elem_count, rows[i].eel);
      end
      if (rows[i].evd) begin
        n_vec++;
        if (res !== rows[i].eres) begin
          n_err++;
          $display("FAIL single_result[%0d]: got %0d, want %0d", i, res, rows[i].eres);
        end
      end
    end
    n_vec++;
    if (vec_count !== 16'd1) begin
      n_err++;
      $display("FAIL single_vec_count: got %0d, want 1", vec_count);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(mk(1, 2, 5, 1, 1,  0, 0, 1, 0,  0, 0));
    rows.push_back(mk(1, 4, 4, 0, 1,  2, 5, 0, 0,  0, 1));
    rows.push_back(mk(1, 1, 1, 1, 1,  4, 4, 0, 1, 10, 1));
    rows.push_back(mk(0, 0, 0, 0, 1,  1, 1, 1, 0,  0, 2));
    rows.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 1, 17, 0));
    rows.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 0,  0, 0));
    foreach (rows[i]) begin
      drive(rows[i].v, rows[i].a, rows[i].b, rows[i].l);
      run = rows[i].r;
      tick();
      n_vec++;
      if ({macc_a, macc_b, macc_ae, vec_done} !== {rows[i].ea, rows[i].eb, rows[i].eae, rows[i].evd}) begin
        n_err++;
        $display("FAIL b2b[%0d]: got a=%0d b=%0d ae=%b done=%b, want a=%0d b=%0d ae=%b done=%b",
                 i, macc_a, macc_b, macc_ae, vec_done, rows[i].ea, rows[i].eb, rows[i].eae, rows[i].evd);
      end
      n_vec++;
      if (elem_count !== 16'(rows[i].eel)) begin
        n_err++;
        $display("FAIL b2b_elem[%0d]: got %0d, want %0d", i, elem_count, rows[i].eel);
      end
      if (rows[i].evd) begin
        n_vec++;
        if (res !== rows[i].eres) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: got %0d, want %0d", i, res, rows[i].eres);
        end
      end
    end
    n_vec++;
    if (vec_count !== 16'd3) begin
      n_err++;
      $display("FAIL b2b_vec_count: got %0d, want 3", vec_count);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    run = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 32'(10 + k), 32'(k), k == 4);
      n_vec++;
      if (sif.s_ready !== (k <= 4)) begin
        n_err++;
        $display("FAIL bp_ready_offer%0d: got %b, want %b", k, sif.s_ready, k <= 4);
      end
      if (sif.s_ready === 1'b1) accepted++;
      tick();
    end
    n_vec++;
    if (accepted != 4) begin
      n_err++;
      $display("FAIL bp_accepted: got %0d, want 4", accepted);
    end
    n_vec++;
    if (sif.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_full: got %b, want 0", sif.s_ready);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    run = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_vec++;
      if ({macc_a, macc_b, macc_ae} !== {32'(10 + j), 32'(j), j != 1}) begin
        n_err++;
        $display("FAIL bp_drain%0d: got a=%0d b=%0d ae=%b, want a=%0d b=%0d ae=%b",
                 j, macc_a, macc_b, macc_ae, 10 + j, j, j != 1);
      end
      if (j == 1) begin
        n_vec++;
        if (sif.s_ready !== 1'b1) begin
          n_err++;
          $display("FAIL bp_ready_after_pop: got %b, want 1", sif.s_ready);
        end
      end
    end
    tick();
    n_vec++;
    if ({vec_done, res, vec_count} !== {1'b1, 64'd130, 16'd4}) begin
      n_err++;
      $display("FAIL bp_done: got done=%b result=%0d vec=%0d, want done=1 result=130 vec=4",
               vec_done, res, vec_count);
    end
  endtask

  task automatic test_bubbles();
    row_t rows[$];
    rows.push_back(mk(1, 5, 5, 0, 1,  0, 0, 1, 0,  0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1,  5, 5, 0, 0,  0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 0,  0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 0,  0, 1));
    rows.push_back(mk(1, 1, 2, 1, 1,  0, 0, 1, 0,  0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1,  1, 2, 1, 0,  0, 2));
    rows.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 1, 27, 0));
    foreach (rows[i]) begin
      drive(rows[i].v, rows[i].a, rows[i].b, rows[i].l);
      run = rows[i].r;
      tick();
      n_vec++;
      if ({macc_a, macc_b, macc_ae, vec_done} !== {rows[i].ea, rows[i].eb, rows[i].eae, rows[i].evd}) begin
        n_err++;
        $display("FAIL bubble[%0d]: got a=%0d b=%0d ae=%b done=%b, want a=%0d b=%0d ae=%b done=%b",
                 i, macc_a, macc_b, macc_ae, vec_done, rows[i].ea, rows[i].eb, rows[i].eae, rows[i].evd);
      end
      n_vec++;
      if (elem_count !== 16'(rows[i].eel)) begin
        n_err++;
        $display("FAIL bubble_elem[%0d]: got %0d, want %0d", i, elem_count, rows[i].eel);
      end
      if (rows[i].evd) begin
        n_vec++;
        if (res !== rows[i].eres) begin
          n_err++;
          $display("FAIL bubble_result[%0d]: got %0d, want %0d", i, res, rows[i].eres);
        end
      end
    end
    n_vec++;
    if (vec_count !== 16'd5) begin
      n_err++;
      $display("FAIL bubble_vec_count: got %0d, want 5", vec_count);
    end
  endtask

  task automatic test_reset_mid_vector();
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'd1, 32'd1, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    n_vec++;
    if (elem_count !== 16'd2) begin
      n_err++;
      $display("FAIL rstmid_pre_elem: got %0d, want 2", elem_count);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({sif.s_ready, macc_a, macc_b, macc_ae, vec_done, elem_count, vec_count} !==
        {1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 16'd0, 16'd0}) begin
      n_err++;
      $display("FAIL rstmid_async: got rdy=%b a=%0d b=%0d ae=%b done=%b elem=%0d vec=%0d, want rdy=1 a=0 b=0 ae=1 done=0 elem=0 vec=0",
               sif.s_ready, macc_a, macc_b, macc_ae, vec_done, elem_count, vec_count);
    end
    @(negedge clk) rst = 1'b1;
    run = 1'b1;
    // FIFO must be empty: nothing issues even with run high.
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if ({macc_a, macc_b, macc_ae, vec_done, elem_count, vec_count} !==
          {32'd0, 32'd0, 1'b1, 1'b0, 16'd0, 16'd0}) begin
        n_err++;
        $display("FAIL rstmid_empty[%0d]: got a=%0d b=%0d ae=%b done=%b elem=%0d vec=%0d, want idle and zero counts",
                 i, macc_a, macc_b, macc_ae, vec_done, elem_count, vec_count);
      end
    end
    drive(1'b1, 32'd7, 32'd3, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    n_vec++;
    if ({macc_a, macc_b, macc_ae, elem_count} !== {32'd7, 32'd3, 1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL rstmid_restart: got a=%0d b=%0d ae=%b elem=%0d, want a=7 b=3 ae=0 elem=1",
               macc_a, macc_b, macc_ae, elem_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({vec_done, vec_count} !== {1'b0, 16'd0}) begin
        n_err++;
        $display("FAIL rstmid_no_done[%0d]: got done=%b vec=%0d, want done=0 vec=0", i, vec_done, vec_count);
      end
    end
    n_vec++;
    if (res !== 64'd21) begin
      n_err++;
      $display("FAIL rstmid_result: got %0d, want 21", res);
    end
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_mid_vector();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
